// File: rtl/mdu_sched_if.sv
// Handshake/bus bundle between the E/D pipeline stages and the multiply/divide scheduler.
// The pipeline side drives issue info; the MDU side returns busy, stall and HI/LO.
interface mdu_sched_if;
  logic        E_start;
  logic [2:0]  E_MDOp;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_is_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output E_start, E_MDOp, E_A, E_B, D_is_md,
    input  busy, md_stall, HI, LO
  );

  modport slave (
    input  E_start, E_MDOp, E_A, E_B, D_is_md,
    output busy, md_stall, HI, LO
  );
endinterface

// File: rtl/mdu_sched.sv
// Multiply/divide scheduler: computes the result at issue, parks it in temp regs and
// commits to HI/LO after a fixed latency (5 for mult, 10 for div) to mimic a real MDU.
module mdu_sched (
  input  logic      clk,
  input  logic      reset,
  mdu_sched_if.slave bus
);
  typedef enum logic [2:0] {
    OpNone  = 3'd0,
    OpMult  = 3'd1,
    OpMultu = 3'd2,
    OpDiv   = 3'd3,
    OpDivu  = 3'd4,
    OpMthi  = 3'd5,
    OpMtlo  = 3'd6,
    OpRsvd  = 3'd7
  } md_op_e;

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] thi_q, thi_d, tlo_q, tlo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy;
  md_op_e      op;
  logic [63:0] prod_s, prod_u;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;
  logic        b_zero, div_ovf;

  assign op      = md_op_e'(bus.E_MDOp);
  assign busy    = (cnt_q != 4'd0);
  assign b_zero  = (bus.E_B == 32'd0);
  assign div_ovf = (bus.E_A == 32'h8000_0000) && (bus.E_B == 32'hFFFF_FFFF);

  assign prod_s = $signed({{32{bus.E_A[31]}}, bus.E_A}) * $signed({{32{bus.E_B[31]}}, bus.E_B});
  assign prod_u = {32'd0, bus.E_A} * {32'd0, bus.E_B};

  // Guard the signed divider against the two cases whose native result is undefined.
  always_comb begin
    quo_s = bus.E_A;
    rem_s = 32'd0;
    quo_u = 32'd0;
    rem_u = 32'd0;
    if (!b_zero && !div_ovf) begin
      quo_s = 32'($signed(bus.E_A) / $signed(bus.E_B));
      rem_s = 32'($signed(bus.E_A) % $signed(bus.E_B));
    end
    if (!b_zero) begin
      quo_u = bus.E_A / bus.E_B;
      rem_u = bus.E_A % bus.E_B;
    end
  end

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    thi_d = thi_q;
    tlo_d = tlo_q;
    cnt_d = cnt_q;
    if (cnt_q == 4'd1) begin
      cnt_d = 4'd0;
      hi_d  = thi_q;
      lo_d  = tlo_q;
    end else if (busy) begin
      cnt_d = cnt_q - 4'd1;
    end else if (bus.E_start) begin
      unique case (op)
        OpMult: begin
          {thi_d, tlo_d} = prod_s;
          cnt_d          = 4'd5;
        end
        OpMultu: begin
          {thi_d, tlo_d} = prod_u;
          cnt_d          = 4'd5;
        end
        OpDiv, OpDivu: begin
          // Divide by zero re-commits the current HI/LO so they appear unchanged.
          if (b_zero) begin
            thi_d = hi_q;
            tlo_d = lo_q;
          end else if (op == OpDiv) begin
            thi_d = rem_s;
            tlo_d = quo_s;
          end else begin
            thi_d = rem_u;
            tlo_d = quo_u;
          end
          cnt_d = 4'd10;
        end
        OpMthi:  hi_d = bus.E_A;
        OpMtlo:  lo_d = bus.E_A;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      thi_q <= 32'd0;
      tlo_q <= 32'd0;
      cnt_q <= 4'd0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      thi_q <= thi_d;
      tlo_q <= tlo_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.busy     = busy;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;
  assign bus.md_stall = bus.D_is_md &
                        (busy | (bus.E_start & (op inside {OpMult, OpMultu, OpDiv, OpDivu})));
endmodule

// File: tb/tb_mdu_sched.sv
// Self-checking bench for mdu_sched: directed scenarios plus a randomized run, all
// compared against a timeline model (commit edge index) rather than a cycle counter.
module tb_mdu_sched;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mdu_sched_if bus ();

  mdu_sched u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: pending result becomes architectural at edge index p_done.
  int          edge_n = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  bit          p_active = 0;
  int          p_done = 0;

  task automatic model_edge();
    longint      as, bs;
    logic [63:0] pr;
    if (reset) begin
      m_hi = 0; m_lo = 0; p_active = 0;
    end else if (p_active) begin
      if (edge_n == p_done) begin
        m_hi = p_hi; m_lo = p_lo; p_active = 0;
      end
    end else if (bus.E_start) begin
      as = longint'($signed(bus.E_A));
      bs = longint'($signed(bus.E_B));
      case (bus.E_MDOp)
        3'd1: begin pr = 64'(as * bs); {p_hi, p_lo} = pr; p_active = 1; p_done = edge_n + 5; end
        3'd2: begin
          pr = {32'd0, bus.E_A} * {32'd0, bus.E_B};
          {p_hi, p_lo} = pr; p_active = 1; p_done = edge_n + 5;
        end
        3'd3, 3'd4: begin
          if (bus.E_B == 0) begin
            p_hi = m_hi; p_lo = m_lo;
          end else if (bus.E_MDOp == 3'd3) begin
            p_lo = 32'(as / bs); p_hi = 32'(as % bs);
          end else begin
            p_lo = bus.E_A / bus.E_B; p_hi = bus.E_A % bus.E_B;
          end
          p_active = 1; p_done = edge_n + 10;
        end
        3'd5: m_hi = bus.E_A;
        3'd6: m_lo = bus.E_A;
        default: ;
      endcase
    end
    edge_n++;
  endtask

  function automatic bit exp_stall();
    return bus.D_is_md && (p_active || (bus.E_start && bus.E_MDOp inside {3'd1, 3'd2, 3'd3, 3'd4}));
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit st, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit dmd);
    bus.E_start = st; bus.E_MDOp = op; bus.E_A = a; bus.E_B = b; bus.D_is_md = dmd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 3'd0, 0, 0, 1);
    tick(); tick();
    total++;
    if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      bad++; $display("FAIL reset_state got busy=%b HI=%h LO=%h want 0/0/0", bus.busy, bus.HI, bus.LO);
    end
    #1; total++;
    if (bus.md_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", bus.md_stall); end
    reset = 1'b0;
  endtask

  // Issue op, then hold D_is_md for the whole busy window and check busy/stall/result.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit dmd, input int n,
                        input logic [31:0] want_hi, input logic [31:0] want_lo);
    drive(1, op, a, b, dmd);
    #1; total++;
    if (bus.md_stall !== dmd) begin bad++; $display("FAIL %s start_stall got=%b want=%b", nm, bus.md_stall, dmd); end
    tick();
    drive(0, 3'd0, 0, 0, dmd);
    for (int i = 0; i < n; i++) begin
      total++;
      if (bus.busy !== 1'b1 || bus.md_stall !== dmd) begin
        bad++; $display("FAIL %s busy_win cyc=%0d got busy=%b stall=%b want 1/%b", nm, i, bus.busy, bus.md_stall, dmd);
      end
      tick();
    end
    total++;
    if (bus.busy !== 1'b0 || bus.md_stall !== 1'b0 || bus.HI !== want_hi || bus.LO !== want_lo) begin
      bad++; $display("FAIL %s result got busy=%b stall=%b HI=%h LO=%h want 0/0/%h/%h",
                      nm, bus.busy, bus.md_stall, bus.HI, bus.LO, want_hi, want_lo);
    end
    total++;
    if (bus.HI !== m_hi || bus.LO !== m_lo) begin
      bad++; $display("FAIL %s model got HI=%h LO=%h want %h/%h", nm, bus.HI, bus.LO, m_hi, m_lo);
    end
  endtask

  task automatic test_mult();
    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, 0, 5, 32'h0000_0002, 32'hFFFF_FFFA);
  endtask

  task automatic test_div();
    run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", 3'd4, 32'd7, 32'd2, 1, 10, 32'd1, 32'd3);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 10, 32'd0, 32'h8000_0000);
  endtask

  task automatic test_div_zero();
    drive(1, 3'd5, 32'h11, 0, 0); tick();
    drive(1, 3'd6, 32'h22, 0, 0); tick();
    total++;
    if (bus.busy !== 1'b0 || bus.HI !== 32'h11 || bus.LO !== 32'h22) begin
      bad++; $display("FAIL mthi_mtlo got busy=%b HI=%h LO=%h want 0/11/22", bus.busy, bus.HI, bus.LO);
    end
    run_op("div0", 3'd3, 32'd99, 32'd0, 0, 10, 32'h11, 32'h22);
  endtask

  task automatic test_ignored();
    drive(1, 3'd1, 32'd6, 32'd7, 0); tick();
    drive(1, 3'd1, 32'd100, 32'd100, 0); tick();
    drive(1, 3'd5, 32'hDEAD_BEEF, 0, 0); tick();
    drive(1, 3'd7, 32'h1234, 32'h1, 0); tick();
    drive(0, 3'd0, 0, 0, 0);
    for (int i = 0; i < 2; i++) tick();
    total++;
    if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd42) begin
      bad++; $display("FAIL ignored_start got busy=%b HI=%h LO=%h want 0/0/2a", bus.busy, bus.HI, bus.LO);
    end
    drive(1, 3'd7, 32'h55, 32'h66, 0); tick();
    drive(1, 3'd0, 32'h55, 32'h66, 0); tick();
    total++;
    if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd42) begin
      bad++; $display("FAIL nop_ops got busy=%b HI=%h LO=%h want 0/0/2a", bus.busy, bus.HI, bus.LO);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 3'd3, 32'd100, 32'd7, 0); tick();
    drive(0, 3'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      bad++; $display("FAIL reset_mid got busy=%b HI=%h LO=%h want 0/0/0", bus.busy, bus.HI, bus.LO);
    end
    run_op("mult_after_rst", 3'd1, 32'd5, 32'hFFFF_FFFF, 0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
    for (int i = 0; i < 8; i++) tick();
    total++;
    if (bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFB) begin
      bad++; $display("FAIL no_late_commit got HI=%h LO=%h want ffffffff/fffffffb", bus.HI, bus.LO);
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(),
            $urandom_range(0, 1) == 1);
      #1; total++;
      if (bus.md_stall !== exp_stall()) begin
        bad++; $display("FAIL rnd_stall i=%0d got=%b want=%b", i, bus.md_stall, exp_stall());
      end
      tick();
      total++;
      if (bus.busy !== p_active || bus.HI !== m_hi || bus.LO !== m_lo) begin
        bad++; $display("FAIL rnd_state i=%0d got busy=%b HI=%h LO=%h want %b/%h/%h",
                        i, bus.busy, bus.HI, bus.LO, p_active, m_hi, m_lo);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_reset();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
